// File: rtl/fetch_step_ctrl_if.sv
// ROM read bus between the fetch controller (master) and the instruction ROM (slave).
interface fetch_step_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              Rom_en;
    logic [ADDR_W-1:0] Rom_addr;
    logic [31:0]       Inst_code;

    modport master (output Rom_en, output Rom_addr, input Inst_code);
    modport slave  (input Rom_en, input Rom_addr, output Inst_code);
endinterface

// File: rtl/fetch_step_ctrl.sv
// Instruction-fetch sequencer: debounced button or free-run ticks each trigger
// exactly one ROM read, one instruction capture and one PC+4 update.
module fetch_step_ctrl #(
    parameter int DEB_CNT = 16,
    parameter int RUN_DIV = 1024,
    parameter int ADDR_W  = 6,
    parameter int ROM_LAT = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Button,
    input  logic              Run,
    input  logic [1:0]        Select,
    fetch_step_ctrl_if.master rom,
    output logic [31:0]       PC,
    output logic [31:0]       Inst_reg,
    output logic [7:0]        LED,
    output logic              Busy
);
    localparam int DEB_W = $clog2(DEB_CNT + 1);
    localparam int RUN_W = $clog2(RUN_DIV + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_DIV - 1);
    localparam logic [1:0]       LAT_LOAD = 2'(ROM_LAT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, CAPTURE} state_t;

    state_t           state;
    state_t           state_n;
    logic             btn_meta;
    logic             btn_s;
    logic             btn_db;
    logic             btn_db_q;
    logic [DEB_W-1:0] deb_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic [1:0]       wait_cnt;
    logic             rom_en;
    logic             btn_rise;
    logic             run_tick;
    logic             step;

    // Two-flop synchroniser for the asynchronous push-button.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= Button;
            btn_s    <= btn_meta;
        end
    end

    // Debounce: the level only follows btn_s after DEB_CNT consecutive disagreeing cycles.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            deb_cnt  <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s != btn_db) begin
                if (deb_cnt == DEB_LAST) begin
                    btn_db  <= btn_s;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Free-run divider, parked at zero whenever Run is low so a half-count is forgotten.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            run_cnt <= '0;
        end else if (!Run) begin
            run_cnt <= '0;
        end else if (run_cnt == RUN_LAST) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    assign btn_rise = btn_db & ~btn_db_q;
    assign run_tick = Run && (run_cnt == RUN_LAST);
    assign step     = Run ? run_tick : btn_rise;

    // FSM state register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and ROM strobe; steps outside IDLE are simply not looked at.
    always_comb begin
        state_n = state;
        rom_en  = 1'b0;
        case (state)
            IDLE:    if (step) state_n = FETCH;
            FETCH: begin
                rom_en  = 1'b1;
                state_n = WAIT;
            end
            WAIT:    if (wait_cnt == 2'd0) state_n = CAPTURE;
            CAPTURE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ROM latency counter, loaded on the strobe and run down while waiting.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wait_cnt <= 2'd0;
        end else if (state == FETCH) begin
            wait_cnt <= LAT_LOAD;
        end else if (state == WAIT && wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
        end
    end

    // Capture the instruction and advance the PC (32-bit wrap) in CAPTURE only.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            PC       <= 32'd0;
            Inst_reg <= 32'd0;
        end else if (state == CAPTURE) begin
            Inst_reg <= rom.Inst_code;
            PC       <= PC + 32'd4;
        end
    end

    // Registered LED byte mux, refreshed every cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            LED <= 8'd0;
        end else begin
            case (Select)
                2'd0:    LED <= Inst_reg[7:0];
                2'd1:    LED <= Inst_reg[15:8];
                2'd2:    LED <= Inst_reg[23:16];
                default: LED <= Inst_reg[31:24];
            endcase
        end
    end

    assign rom.Rom_en   = rom_en;
    assign rom.Rom_addr = PC[ADDR_W+1:2];
    assign Busy         = (state != IDLE);
endmodule

// File: tb/tb_fetch_step_ctrl.sv
// Bench for fetch_step_ctrl: three instances with different RUN_DIV/ROM_LAT share
// one stimulus stream; a timestamp-style model predicts every output each cycle.
module tb_fetch_step_ctrl;
    logic       Clk = 1'b0;
    logic       Rst;
    logic       Button = 1'b0;
    logic       Run = 1'b0;
    logic [1:0] Select = 2'd0;

    always #5 Clk = ~Clk;

    logic [31:0] d_pc [3];
    logic [31:0] d_ir [3];
    logic [7:0]  d_led [3];
    logic        d_en [3];
    logic [5:0]  d_addr [3];
    logic        d_busy [3];
    logic [31:0] e_pc [3];
    logic [31:0] e_ir [3];
    logic [7:0]  e_led [3];
    logic        e_en [3];
    logic [5:0]  e_addr [3];
    logic        e_busy [3];

    int vectors = 0;
    int miscompares = 0;
    int cyc_no = 0;
    logic [5:0] p_addr [3][$];
    int         p_cyc  [3][$];

    function automatic logic [31:0] rom_word(input logic [5:0] a);
        return 32'h1122_3344 + 32'h0101_0101 * {26'd0, a};
    endfunction

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : inst
            localparam int RD  = (g == 2) ? 2 : 8;
            localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

            fetch_step_ctrl_if #(.ADDR_W(6)) rif ();
            logic [31:0] pc_w;
            logic [31:0] ir_w;
            logic [7:0]  led_w;
            logic        busy_w;

            fetch_step_ctrl #(.DEB_CNT(4), .RUN_DIV(RD), .ADDR_W(6), .ROM_LAT(LAT)) dut (
                .Clk(Clk), .Rst(Rst), .Button(Button), .Run(Run), .Select(Select),
                .rom(rif), .PC(pc_w), .Inst_reg(ir_w), .LED(led_w), .Busy(busy_w)
            );

            // ROM: data appears LAT cycles after the strobe, junk until then.
            logic [31:0] rom_q = 32'hDEAD_BEEF;
            logic [5:0]  r_addr = 6'd0;
            int          lat_c = 0;
            always @(posedge Clk) begin
                if (rif.Rom_en) begin
                    r_addr <= rif.Rom_addr;
                    if (LAT == 1) begin
                        rom_q <= rom_word(rif.Rom_addr);
                        lat_c <= 0;
                    end else begin
                        rom_q <= 32'hDEAD_BEEF;
                        lat_c <= LAT - 1;
                    end
                end else if (lat_c == 1) begin
                    rom_q <= rom_word(r_addr);
                    lat_c <= 0;
                end else if (lat_c > 1) begin
                    lat_c <= lat_c - 1;
                end
            end
            assign rif.Inst_code = rom_q;

            // Model: a fetch is a window of LAT+2 busy cycles; strobe on the first, commit on the last.
            logic        m_s1 = 0, m_s2 = 0, m_db = 0, m_dbp = 0;
            int          m_dis = 0, m_run = 0, m_busy = 0;
            logic [31:0] m_pc = 0, m_ir = 0;
            logic [7:0]  m_led = 0;
            always begin
                @(posedge Clk or negedge Rst);
                if (!Rst) begin
                    m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0;
                    m_dis = 0; m_run = 0; m_busy = 0;
                    m_pc = 0; m_ir = 0; m_led = 0;
                end else begin
                    logic st;
                    st = Run ? (m_run == RD - 1) : (m_db && !m_dbp);
                    m_led = m_ir[8*Select +: 8];
                    if (m_busy == 1) begin
                        m_ir = rom_word(m_pc[7:2]);
                        m_pc = m_pc + 32'd4;
                    end
                    if (m_busy > 0) m_busy = m_busy - 1;
                    else if (st) m_busy = LAT + 2;
                    m_run = Run ? (m_run + 1) % RD : 0;
                    m_dbp = m_db;
                    if (m_s2 != m_db) begin
                        if (m_dis == 3) begin m_db = m_s2; m_dis = 0; end
                        else m_dis = m_dis + 1;
                    end else begin
                        m_dis = 0;
                    end
                    m_s2 = m_s1;
                    m_s1 = Button;
                end
            end

            assign d_pc[g] = pc_w;    assign e_pc[g] = m_pc;
            assign d_ir[g] = ir_w;    assign e_ir[g] = m_ir;
            assign d_led[g] = led_w;  assign e_led[g] = m_led;
            assign d_en[g] = rif.Rom_en;   assign e_en[g] = (m_busy == LAT + 2);
            assign d_addr[g] = rif.Rom_addr; assign e_addr[g] = m_pc[7:2];
            assign d_busy[g] = busy_w; assign e_busy[g] = (m_busy != 0);
        end
    endgenerate

    task automatic chk(input string nm, input int gi, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s[%0d] cycle %0d: got 0x%08h, expected 0x%08h", nm, gi, cyc_no, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        cyc_no++;
        for (int i = 0; i < 3; i++) begin
            chk("pc", i, d_pc[i], e_pc[i]);
            chk("inst_reg", i, d_ir[i], e_ir[i]);
            chk("led", i, 32'(d_led[i]), 32'(e_led[i]));
            chk("rom_en", i, 32'(d_en[i]), 32'(e_en[i]));
            chk("rom_addr", i, 32'(d_addr[i]), 32'(e_addr[i]));
            chk("busy", i, 32'(d_busy[i]), 32'(e_busy[i]));
            if (d_en[i]) begin
                p_addr[i].push_back(d_addr[i]);
                p_cyc[i].push_back(cyc_no);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_pulses();
        for (int i = 0; i < 3; i++) begin
            p_addr[i].delete();
            p_cyc[i].delete();
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((d_busy[0] || d_busy[1] || d_busy[2]) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", 0, 32'(n >= budget), 32'd0);
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        ticks(2);
        Rst = 1'b1;
        tick();
    endtask

    task automatic check_run_pulses(input int gi, input int cnt, input int pc);
        chk("run_pulses", gi, 32'(p_addr[gi].size()), 32'(cnt));
        for (int k = 0; k < p_addr[gi].size(); k++)
            chk("run_addr", gi, 32'(p_addr[gi][k]), 32'(k));
        for (int k = 1; k < p_cyc[gi].size(); k++)
            chk("run_gap", gi, 32'(p_cyc[gi][k] - p_cyc[gi][k-1]), 32'd8);
        chk("run_pc", gi, d_pc[gi], 32'(pc));
    endtask

    initial begin
        int n;
        Rst = 1'b0;
        ticks(3);
        chk("reset_pc", 0, d_pc[0], 32'd0);
        chk("reset_busy", 0, 32'(d_busy[0]), 32'd0);
        chk("reset_en", 0, 32'(d_en[0]), 32'd0);
        Rst = 1'b1;
        ticks(2);

        // Clean press
        clear_pulses();
        Button = 1'b1; ticks(20);
        Button = 1'b0; ticks(20);
        chk("t1_pulses", 0, 32'(p_addr[0].size()), 32'd1);
        if (p_addr[0].size() > 0) chk("t1_addr", 0, 32'(p_addr[0][0]), 32'd0);
        chk("t1_inst", 0, d_ir[0], 32'h1122_3344);
        chk("t1_pc", 0, d_pc[0], 32'd4);
        chk("t1_led_sel0", 0, 32'(d_led[0]), 32'h44);
        Select = 2'd3; tick();
        chk("t1_led_sel3", 0, 32'(d_led[0]), 32'h11);
        Select = 2'd0; tick();

        // Bouncy press
        clear_pulses();
        for (int i = 0; i < 6; i++) begin
            Button = (i % 2 == 0);
            ticks(2);
        end
        chk("t2_bounce_pulses", 0, 32'(p_addr[0].size()), 32'd0);
        Button = 1'b1; ticks(20);
        Button = 1'b0; ticks(20);
        chk("t2_pulses", 0, 32'(p_addr[0].size()), 32'd1);
        chk("t2_pc", 0, d_pc[0], 32'd8);
        chk("t2_inst", 0, d_ir[0], 32'h1223_3445);

        // Free run with the button wiggling; ticks during Busy dropped on instance 2
        do_reset();
        clear_pulses();
        Run = 1'b1;
        for (int c = 0; c < 34; c++) begin
            Button = (c < 24) && ((c / 5) % 2 == 1);
            tick();
        end
        Run = 1'b0;
        Button = 1'b0;
        wait_idle(20);
        ticks(12);
        check_run_pulses(1, 4, 16);
        check_run_pulses(0, 4, 16);
        check_run_pulses(2, 5, 20);

        // 64 steps to reach the address wrap
        do_reset();
        Run = 1'b1;
        ticks(512);
        Run = 1'b0;
        wait_idle(20);
        ticks(4);
        chk("t5_pc", 0, d_pc[0], 32'h100);
        chk("t5_addr", 0, 32'(d_addr[0]), 32'd0);
        chk("t5_inst", 0, d_ir[0], 32'h5061_7283);
        chk("t5_pc", 2, d_pc[2], 32'h100);
        clear_pulses();
        Button = 1'b1; ticks(20);
        Button = 1'b0; ticks(20);
        chk("t5_next_pulses", 0, 32'(p_addr[0].size()), 32'd1);
        if (p_addr[0].size() > 0) chk("t5_next_addr", 0, 32'(p_addr[0][0]), 32'd0);
        chk("t5_next_pc", 0, d_pc[0], 32'h104);
        chk("t5_next_inst", 0, d_ir[0], 32'h1122_3344);

        // Reset during WAIT
        Button = 1'b1;
        n = 0;
        while (!(d_busy[2] && !d_en[2]) && n < 40) begin
            tick();
            n++;
        end
        chk("t6_wait_timeout", 2, 32'(n >= 40), 32'd0);
        tick();
        #2;
        Button = 1'b0;
        Rst = 1'b0;
        #1;
        chk("t6_pc_now", 2, d_pc[2], 32'd0);
        chk("t6_inst_now", 2, d_ir[2], 32'd0);
        chk("t6_led_now", 2, 32'(d_led[2]), 32'd0);
        chk("t6_busy_now", 2, 32'(d_busy[2]), 32'd0);
        ticks(3);
        Rst = 1'b1;
        clear_pulses();
        ticks(15);
        chk("t6_no_capture_pc", 2, d_pc[2], 32'd0);
        chk("t6_no_capture_inst", 2, d_ir[2], 32'd0);
        chk("t6_no_fetch", 2, 32'(p_addr[2].size()), 32'd0);
        Button = 1'b1; ticks(20);
        Button = 1'b0; ticks(20);
        chk("t6_pulses", 2, 32'(p_addr[2].size()), 32'd1);
        if (p_addr[2].size() > 0) chk("t6_addr", 2, 32'(p_addr[2][0]), 32'd0);
        chk("t6_pc", 2, d_pc[2], 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_step_ctrl.md
Name: fetch_step_ctrl

Overview:
- Sequences the instruction-fetch datapath: program counter, instruction ROM read and LED byte display.
- Replaces raw button clocking. All logic runs on the single system clock Clk.
- Button is synchronised and debounced. Each press, or each run-mode tick, produces exactly one ROM fetch, one instruction capture and one PC+4 update.
- Sits between the board inputs (Button, Select, Run) and the instruction ROM core and LEDs.

Parameters:
- DEB_CNT, default 16: Clk cycles the synchronised button must stay stable before the debounced level changes.
- RUN_DIV, default 1024: Clk cycles between automatic step requests when Run=1.
- ADDR_W, default 6: ROM word-address width. Rom_addr = PC[ADDR_W+1:2].
- ROM_LAT, default 1: Clk cycles from the Rom_en pulse to valid Inst_code. Legal range 1..4.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset. Rst=0 resets all state.
- Button  in  1  raw push-button, active-high, asynchronous and bouncy.
- Run  in  1  1 = free-run stepping every RUN_DIV cycles. Button is ignored while Run=1.
- Select  in  2  chooses which Inst_reg byte drives LED.
- Inst_code  in  32  ROM read data.
- Rom_en  out  1  one-cycle ROM read strobe.
- Rom_addr  out  ADDR_W  ROM word address.
- PC  out  32  program counter.
- Inst_reg  out  32  last captured instruction.
- LED  out  8  selected byte of Inst_reg.
- Busy  out  1  high while a fetch is in progress (state != IDLE).

Behaviour:
- Reset (Rst=0, asynchronous):
  - Outputs: PC=0, Inst_reg=0, LED=0, Rom_en=0, Busy=0, Rom_addr=0.
  - Internal state: FSM=IDLE, debounce counter=0, debounced level=0, run counter=0, synchroniser flops=0.
  - Reset asserted mid-fetch aborts the fetch. No PC update and no capture occur.
- Synchroniser: two flops on Button; sync output is btn_s.
- Debounce:
  - If btn_s differs from the debounced level btn_db, the counter increments; otherwise it clears.
  - When the counter reaches DEB_CNT-1 while btn_s still differs, btn_db<=btn_s and the counter clears.
  - Any bounce clears the counter.
- Step request:
  - Run=0: step = one-cycle pulse on the 0->1 transition of btn_db. Release generates nothing.
  - Run=1: the run counter counts 0..RUN_DIV-1 and step pulses when it wraps to 0.
  - The run counter is held at 0 while Run=0.
  - Button edges are discarded while Run=1.
  - Run switching 1->0 mid-count cancels the pending tick.
- FSM states: IDLE, FETCH, WAIT, CAPTURE.
  - IDLE: on step go to FETCH. Otherwise stay.
  - FETCH, one cycle: Rom_en=1, Rom_addr=PC[ADDR_W+1:2]. Load the wait counter with ROM_LAT-1. Go to WAIT.
  - WAIT: decrement the wait counter. At 0 go to CAPTURE. With ROM_LAT=1, WAIT lasts exactly one cycle.
  - CAPTURE, one cycle: Inst_reg<=Inst_code, PC<=PC+4, then go to IDLE.
  - Rom_en is 0 in every state except FETCH.
- Rom_addr holds PC[ADDR_W+1:2] at all times; it is not only driven in FETCH.
- Timing: step to Inst_reg/PC update is 2+ROM_LAT cycles. The next step is accepted the cycle after CAPTURE.
- Step pulses arriving while Busy=1 are dropped, not queued.
- Arithmetic:
  - PC is 32-bit and wraps 0xFFFFFFFC -> 0x00000000.
  - Rom_addr wraps naturally, for ADDR_W=6 from 63 to 0 at PC=0x100.
  - PC[1:0] is always 0.
- LED is registered and updated every cycle:
  - Select 0 -> Inst_reg[7:0]
  - Select 1 -> Inst_reg[15:8]
  - Select 2 -> Inst_reg[23:16]
  - Select 3 -> Inst_reg[31:24]
- LED latency: 1 cycle after a Select or Inst_reg change.
- Step and CAPTURE in the same cycle: the step is dropped, because the FSM is not in IDLE.

Test Plan:
1. Reset, DEB_CNT=4, ROM model ROM_LAT=1 returning 0x11223344 at address 0. Clean press held 20 cycles. Required:
   - exactly one Rom_en pulse, with Rom_addr=0;
   - Inst_reg=0x11223344 and PC=4;
   - LED=0x44 with Select=0, then 0x11 one cycle after Select=3.
2. Bouncy press: Button toggles every 2 cycles for 12 cycles, then holds 1. Required: exactly one fetch. Bounce shorter than DEB_CNT produces no fetch.
3. Run=1, RUN_DIV=8, ROM_LAT=2, Button toggling. Required:
   - Rom_en every 8 cycles;
   - PC advances 0,4,8,12 after four ticks;
   - Button has no effect.
4. Step held off: force Run=1, RUN_DIV=2, ROM_LAT=4. Required: ticks during Busy are dropped, and PC increments once per completed fetch only.
5. PC preset by 64 steps. Required: after the 64th step PC=0x100 and the next Rom_addr=0 (address wrap).
6. Rst=0 asserted during WAIT. Required:
   - PC, Inst_reg and LED go to 0 immediately;
   - no capture occurs after release;
   - the next press fetches address 0.
